// File: rtl/score_bcd_converter.sv
// -----------------------------------------------------------------------------
// score_bcd_converter
//
// Converts the binary running score into packed BCD digits plus a
// leading-zero blanking mask for the score display. Conversion is
// sequential shift-add-3 (double dabble), one input bit per clock, and is
// re-triggered automatically whenever the sampled score differs from the
// last value converted.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   score    - binary score input (BIN_W bits), may change on any cycle
//   bcd      - packed BCD result, digit i in bits [4i+3:4i], digit 0 = LSD
//   digit_en - per-digit display enable, 1 for digits at or below the
//              most-significant nonzero digit; bit 0 always 1
//   busy     - high while a conversion is in progress (SHIFT and DONE)
//   done     - one-cycle pulse coincident with bcd/digit_en update
//
// Parameter constraint: 10^DIGITS > 2^BIN_W - 1 (defaults satisfy it).
// -----------------------------------------------------------------------------
module score_bcd_converter #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [BIN_W-1:0]      score,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Apply the +3 correction to every scratch digit >= 5, all in parallel
    // from the same snapshot so corrections never feed into each other.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Enable digit i when any digit at or above i is nonzero; digit 0 is
    // always shown so a zero score still displays "0".
    function automatic logic [DIGITS-1:0] lead_mask(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] m;
        logic              seen;
        seen = 1'b0;
        m    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (v[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    state_t               r_state;
    logic [BIN_W-1:0]     r_last;
    logic [BIN_W-1:0]     r_bin_sr;
    logic [BCD_W-1:0]     r_bcd_sr;
    logic [CNT_W-1:0]     r_cnt;
    logic [BCD_W-1:0]     r_bcd;
    logic [DIGITS-1:0]    r_digit_en;
    logic                 r_busy;
    logic                 r_done;

    logic [BCD_W-1:0]     w_bcd_adj;
    logic [DIGITS-1:0]    w_digit_en;

    // Combinational correction of the scratch and leading-zero mask.
    always_comb begin
        w_bcd_adj  = add3_all(r_bcd_sr);
        w_digit_en = lead_mask(r_bcd_sr);
    end

    // Conversion FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_last     <= '0;
            r_bin_sr   <= '0;
            r_bcd_sr   <= '0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_digit_en <= {{(DIGITS-1){1'b0}}, 1'b1};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (score != r_last) begin
                        r_bin_sr <= score;
                        r_last   <= score;
                        r_bcd_sr <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // {bcd_sr, bin_sr} shifted left after correction.
                    r_bcd_sr <= {w_bcd_adj[BCD_W-2:0], r_bin_sr[BIN_W-1]};
                    r_bin_sr <= {r_bin_sr[BIN_W-2:0], 1'b0};
                    r_cnt    <= r_cnt + CNT_W'(1);
                    r_busy   <= 1'b1;
                    if (r_cnt == CNT_W'(BIN_W - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // busy stays high through this cycle's output update.
                    r_bcd      <= r_bcd_sr;
                    r_digit_en <= w_digit_en;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd      = r_bcd;
    assign digit_en = r_digit_en;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_score_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_score_bcd_converter
//
// Scoreboard bench: each score driven pushes its expected BCD, digit enable
// and completion cycle; a negedge monitor pops and compares on every done.
// -----------------------------------------------------------------------------
module tb_score_bcd_converter;

    logic        clk;
    logic        reset_n;
    logic [31:0] score;
    logic [39:0] bcd;
    logic [9:0]  digit_en;
    logic        busy;
    logic        done;

    typedef struct {
        logic [39:0] bcd;
        logic [9:0]  en;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    logic prev_done;

    score_bcd_converter #(.BIN_W(32), .DIGITS(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .score    (score),
        .bcd      (bcd),
        .digit_en (digit_en),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a negedge it equals the number of the preceding posedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference BCD by repeated division.
    function automatic logic [39:0] ref_bcd(input logic [31:0] v);
        logic [39:0]     r;
        longint unsigned x;
        x = longint'(v);
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference enable: one bit per decimal digit of v (minimum one).
    function automatic logic [9:0] ref_en(input logic [31:0] v);
        longint unsigned x;
        int              n;
        logic [10:0]     m;
        x = longint'(v);
        n = 1;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        m = (11'd1 << n) - 11'd1;
        return m[9:0];
    endfunction

    task automatic drive(input logic [31:0] v, input int lat);
        exp_t e;
        @(negedge clk);
        score = v;
        e.bcd = ref_bcd(v);
        e.en  = ref_en(v);
        e.cyc = cyc + lat;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && done) begin
            chk("done_gap", 64'(prev_done), 64'd0);
            chk("busy_at_done", 64'(busy), 64'd1);
            if (q.size() == 0) begin
                chk("spurious_done", 64'(done), 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("bcd", 64'(bcd), 64'(mon_e.bcd));
                chk("digit_en", 64'(digit_en), 64'(mon_e.en));
                chk("latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        prev_done <= done;
    end

    initial begin
        exp_t e;
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        prev_done = 1'b0;
        reset_n   = 1'b0;
        score     = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset / idle with score 0
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_en", 64'(digit_en), 64'h001);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        repeat (100) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Basic conversion, then hold
        drive(32'd1234, 34);
        wait_drain(60);
        repeat (40) @(negedge clk);
        chk("hold_busy", 64'(busy), 64'd0);

        // Maximum value, then back to zero
        drive(32'hFFFF_FFFF, 34);
        wait_drain(60);
        drive(32'd0, 34);
        wait_drain(60);

        // Change while busy
        drive(32'd500, 34);
        repeat (4) @(negedge clk);
        drive(32'd7, 63);
        for (int i = 0; i < 60 && q.size() > 1; i++) @(negedge clk);
        repeat (15) @(negedge clk);
        chk("hold_bcd_mid", 64'(bcd), 64'h500);
        chk("busy_mid", 64'(busy), 64'd1);
        wait_drain(80);
        repeat (5) @(negedge clk);

        // Reset mid-conversion
        @(negedge clk);
        score = 32'd99999;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bcd", 64'(bcd), 64'd0);
        chk("mid_rst_en", 64'(digit_en), 64'h001);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        e.bcd = ref_bcd(32'd99999);
        e.en  = ref_en(32'd99999);
        e.cyc = cyc + 34;
        q.push_back(e);
        wait_drain(60);

        // Digit-boundary sweep
        drive(32'd9, 34);          wait_drain(60);
        drive(32'd10, 34);         wait_drain(60);
        drive(32'd99, 34);         wait_drain(60);
        drive(32'd100, 34);        wait_drain(60);
        drive(32'd1000000000, 34); wait_drain(60);
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
